// File: rtl/m_axi_pkg.sv
// Shared types and constants for the AXI read engine: FSM state encoding,
// fixed AXI attribute values and an elaboration-time clog2 helper.
package m_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_MOD  = 4'b0010;  // normal, non-cacheable, modifiable
  localparam logic [2:0] AXI_PROT_NS    = 3'b010;   // unprivileged, non-secure, data
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction

endpackage

// File: rtl/m_axi_sfifo.sv
// Synchronous FIFO on a simple dual-port RAM with a registered read port.
// Read data appears one cycle after I_rd_en; the array itself is not reset so
// it maps onto block RAM. Pointers wrap modulo C_DEPTH.
module m_axi_sfifo
  import m_axi_pkg::*;
#(
  parameter int C_WIDTH = 128,
  parameter int C_DEPTH = 256,
  localparam int PTR_W  = (C_DEPTH > 1) ? clog2(C_DEPTH) : 1,
  localparam int CNT_W  = clog2(C_DEPTH) + 1
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_wr_en,
  input  logic [C_WIDTH-1:0] I_wr_data,
  input  logic               I_rd_en,
  output logic [C_WIDTH-1:0] O_rd_data,
  output logic [CNT_W-1:0]   O_count,
  output logic               O_empty
);

  logic [C_WIDTH-1:0] mem [C_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               wr_ok, rd_ok;

  assign wr_ok     = I_wr_en && (count != CNT_W'(C_DEPTH));
  assign rd_ok     = I_rd_en && (count != '0);
  assign O_count   = count;
  assign O_empty   = (count == '0);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(C_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // RAM write port
  always_ff @(posedge I_clk) begin
    if (wr_ok) mem[wr_ptr] <= I_wr_data;
  end

  // RAM registered read port; holds its value when not reading
  always_ff @(posedge I_clk) begin
    if (rd_ok) O_rd_data <= mem[rd_ptr];
  end

  // pointers and occupancy; simultaneous push/pop leaves count unchanged
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    end
  end

endmodule

// File: rtl/m_axi_rd_engine.sv
// AXI4 read master: turns a (byte address, byte length) job into INCR bursts,
// buffers returning beats in a FIFO and streams them out through a registered
// first-word-fall-through stage. AR issue is throttled by outstanding-burst
// count and by FIFO space, with beats of in-flight bursts held in reserve so
// O_rready can stay high for the whole job.
// Build option: define M_AXI_RD_4K_SPLIT_EN to keep bursts inside 4 KB pages.
module m_axi_rd_engine
  import m_axi_pkg::*;
#(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_MAX_BURST  = 16,
  parameter int C_MAX_OUTST  = 4,
  parameter int C_FIFO_DEPTH = 256
) (
  input  logic                    I_clk,
  input  logic                    I_rst_n,
  input  logic                    I_ap_start,
  input  logic [C_ADDR_WIDTH-1:0] I_rd_addr,
  input  logic [31:0]             I_rd_bytes,
  output logic                    O_ap_ready,
  output logic                    O_ap_done,
  output logic                    O_rd_err,
  output logic [C_ADDR_WIDTH-1:0] O_araddr,
  output logic [7:0]              O_arlen,
  output logic                    O_arvalid,
  input  logic                    I_arready,
  output logic [2:0]              O_arsize,
  output logic [1:0]              O_arburst,
  output logic [3:0]              O_arcache,
  output logic [2:0]              O_arprot,
  output logic [3:0]              O_arid,
  output logic                    O_arlock,
  input  logic [C_DATA_WIDTH-1:0] I_rdata,
  input  logic                    I_rvalid,
  input  logic                    I_rlast,
  input  logic [1:0]              I_rresp,
  input  logic [3:0]              I_rid,
  output logic                    O_rready,
  output logic [C_DATA_WIDTH-1:0] O_mem_din,
  output logic                    O_mem_din_valid,
  input  logic                    I_mem_din_ready
);

  localparam int BYTES = C_DATA_WIDTH / 8;
  localparam int OFF_W = clog2(BYTES);
  localparam int CNT_W = clog2(C_FIFO_DEPTH) + 1;

  rd_state_t state, state_nxt;

  logic                    start_q, accept;
  logic [32:0]             bytes_rnd;
  logic [31:0]             job_beats;
  logic [C_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]             remain_q, beats_left_q, resv_q, ar_len_q;
  logic [31:0]             burst_len, free_sp;
  logic [4:0]              outst_q;
  logic                    ar_vld_q, ar_ok, ar_hs, r_beat;
  logic [C_ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]              arlen_q;
  logic                    rd_err_q;
  logic [C_DATA_WIDTH-1:0] ram_q, dout_q;
  logic [CNT_W-1:0]        fifo_cnt;
  logic                    fifo_empty, fifo_rd, ramq_vld, dout_vld, move, out_pop;
  logic                    in_unused;

  // rid is don't-care (single ID); address offset bits are discarded on accept
  assign in_unused = ^{I_rid, I_rd_addr[OFF_W-1:0]};

  assign accept    = (state == ST_IDLE) && I_ap_start && !start_q;
  assign bytes_rnd = {1'b0, I_rd_bytes} + 33'(BYTES - 1);
  assign job_beats = 32'(bytes_rnd >> OFF_W);
  assign ar_hs     = ar_vld_q && I_arready;
  assign r_beat    = I_rvalid && O_rready;
  assign out_pop   = dout_vld && I_mem_din_ready;
  assign free_sp   = 32'(C_FIFO_DEPTH) - 32'(fifo_cnt) - resv_q;

`ifdef M_AXI_RD_4K_SPLIT_EN
  logic [12:0] to_4k;
  logic [31:0] beats_4k;
  assign to_4k    = 13'h1000 - {1'b0, addr_q[11:0]};
  assign beats_4k = 32'(to_4k >> OFF_W);
`endif

  // next burst length: remaining beats capped by max burst (and page end)
  always_comb begin
    burst_len = (remain_q < 32'(C_MAX_BURST)) ? remain_q : 32'(C_MAX_BURST);
`ifdef M_AXI_RD_4K_SPLIT_EN
    if (beats_4k < burst_len) burst_len = beats_4k;
`endif
  end

  assign ar_ok = (state == ST_REQ) && !ar_vld_q && (remain_q != '0) &&
                 (32'(outst_q) < 32'(C_MAX_OUTST)) && (free_sp >= burst_len);

  // FSM state register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state and control outputs
  always_comb begin
    state_nxt  = state;
    O_ap_ready = 1'b0;
    O_ap_done  = 1'b0;
    O_rready   = 1'b0;
    case (state)
      ST_IDLE: begin
        O_ap_ready = 1'b1;
        if (accept) state_nxt = (job_beats == '0) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        O_rready = 1'b1;
        if (ar_hs && (remain_q == ar_len_q)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        O_rready = 1'b1;
        if (beats_left_q == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        O_ap_done = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // job bookkeeping: current address, beats still to request / to deliver
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      start_q      <= 1'b0;
      addr_q       <= '0;
      remain_q     <= '0;
      beats_left_q <= '0;
    end else begin
      start_q <= I_ap_start;
      if (accept) begin
        addr_q       <= {I_rd_addr[C_ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        remain_q     <= job_beats;
        beats_left_q <= job_beats;
      end else begin
        if (ar_hs) begin
          addr_q   <= addr_q + C_ADDR_WIDTH'(ar_len_q << OFF_W);
          remain_q <= remain_q - ar_len_q;
        end
        if (out_pop) beats_left_q <= beats_left_q - 1'b1;
      end
    end
  end

  // AR channel: fields latched on issue and held until the handshake
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ar_vld_q <= 1'b0;
      araddr_q <= '0;
      arlen_q  <= '0;
      ar_len_q <= '0;
    end else if (ar_ok) begin
      ar_vld_q <= 1'b1;
      araddr_q <= addr_q;
      arlen_q  <= 8'(burst_len - 1'b1);
      ar_len_q <= burst_len;
    end else if (ar_hs) begin
      ar_vld_q <= 1'b0;
    end
  end

  // outstanding bursts, reserved FIFO beats and sticky error
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      outst_q  <= '0;
      resv_q   <= '0;
      rd_err_q <= 1'b0;
    end else begin
      outst_q <= outst_q + 5'(ar_hs) - 5'(r_beat && I_rlast);
      resv_q  <= resv_q + (ar_hs ? ar_len_q : '0) - 32'(r_beat);
      if (accept)                                   rd_err_q <= 1'b0;
      else if (r_beat && (I_rresp != AXI_RESP_OKAY)) rd_err_q <= 1'b1;
    end
  end

  m_axi_sfifo #(
    .C_WIDTH (C_DATA_WIDTH),
    .C_DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .I_clk     (I_clk),
    .I_rst_n   (I_rst_n),
    .I_wr_en   (r_beat),
    .I_wr_data (I_rdata),
    .I_rd_en   (fifo_rd),
    .O_rd_data (ram_q),
    .O_count   (fifo_cnt),
    .O_empty   (fifo_empty)
  );

  // two-stage FWFT: RAM output register feeds the output register; a RAM
  // read is issued only when its result is guaranteed a place to land
  assign move    = ramq_vld && (!dout_vld || out_pop);
  assign fifo_rd = !fifo_empty && (!ramq_vld || move);

  // output stage valid tracking and data register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ramq_vld <= 1'b0;
      dout_vld <= 1'b0;
      dout_q   <= '0;
    end else begin
      if (fifo_rd)   ramq_vld <= 1'b1;
      else if (move) ramq_vld <= 1'b0;
      if (move) begin
        dout_q   <= ram_q;
        dout_vld <= 1'b1;
      end else if (out_pop) begin
        dout_vld <= 1'b0;
      end
    end
  end

  assign O_araddr        = araddr_q;
  assign O_arlen         = arlen_q;
  assign O_arvalid       = ar_vld_q;
  assign O_rd_err        = rd_err_q;
  assign O_mem_din       = dout_q;
  assign O_mem_din_valid = dout_vld;
  assign O_arsize        = 3'(OFF_W);
  assign O_arburst       = AXI_BURST_INCR;
  assign O_arcache       = AXI_CACHE_MOD;
  assign O_arprot        = AXI_PROT_NS;
  assign O_arid          = 4'd0;
  assign O_arlock        = 1'b0;

endmodule
